// File: rtl/i2c_slave.sv
// I2C slave with 7-bit addressing that bridges a bus master to a byte-stream device port.
// SCL/SDA are oversampled on clk6x; SDA is only ever requested low (open-drain).
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [7:0] SLAVE_ADDRESS = 8'h42
) (
    input  logic       clk6x,
    input  logic       resetn,
    input  logic       I2C_SDA,
    output logic       I2C_SDADR0_o,
    input  logic       I2C_SCL_i,
    output logic       devsel_o,
    output logic       rw_bit_o,
    output logic [7:0] rxbyte_o,
    output logic       rxbyte_v_o,
    input  logic [7:0] txbyte_i,
    output logic       txbyte_deq_o,
    output logic       tx_nacked_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WR_DATA   = 3'd3;
    localparam logic [2:0] WR_ACK    = 3'd4;
    localparam logic [2:0] RD_DATA   = 3'd5;
    localparam logic [2:0] RD_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       scl_rise, scl_fall, start_seen, stop_seen;
    logic       addr_match;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;

    // Synchronizers and history registers idle high so reset never looks like a bus event.
    always_ff @(posedge clk6x or posedge resetn) begin
        if (resetn) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= I2C_SCL_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= I2C_SDA;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_seen = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_seen  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign addr_match = (shreg[7:1] == SLAVE_ADDRESS[7:1]);

    always_ff @(posedge clk6x or posedge resetn) begin
        if (resetn) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= 8'h00;
            I2C_SDADR0_o <= 1'b0;
            devsel_o     <= 1'b0;
            rw_bit_o     <= 1'b0;
            rxbyte_o     <= 8'h00;
            rxbyte_v_o   <= 1'b0;
            txbyte_deq_o <= 1'b0;
            tx_nacked_o  <= 1'b0;
        end else begin
            rxbyte_v_o   <= 1'b0;
            txbyte_deq_o <= 1'b0;
            tx_nacked_o  <= 1'b0;
            if (start_seen) begin
                state        <= ADDR;
                bit_cnt      <= 4'd0;
                I2C_SDADR0_o <= 1'b0;
                devsel_o     <= 1'b0;
            end else if (stop_seen) begin
                state        <= IDLE;
                bit_cnt      <= 4'd0;
                I2C_SDADR0_o <= 1'b0;
                devsel_o     <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (addr_match) begin
                                devsel_o     <= 1'b1;
                                rw_bit_o     <= shreg[0];
                                I2C_SDADR0_o <= 1'b1;
                                state        <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_bit_o) begin
                                shreg        <= txbyte_i;
                                txbyte_deq_o <= 1'b1;
                                I2C_SDADR0_o <= ~txbyte_i[7];
                                state        <= RD_DATA;
                            end else begin
                                I2C_SDADR0_o <= 1'b0;
                                state        <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt      <= 4'd0;
                            rxbyte_o     <= shreg;
                            rxbyte_v_o   <= 1'b1;
                            I2C_SDADR0_o <= 1'b1;
                            state        <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            I2C_SDADR0_o <= 1'b0;
                            state        <= WR_DATA;
                        end
                    end
                    // Bit 7 is already on the bus; each fall shifts out the next one.
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                bit_cnt      <= 4'd0;
                                I2C_SDADR0_o <= 1'b0;
                                state        <= RD_ACK;
                            end else begin
                                bit_cnt      <= bit_cnt + 4'd1;
                                shreg        <= {shreg[6:0], 1'b0};
                                I2C_SDADR0_o <= ~shreg[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_s2) begin
                            tx_nacked_o <= 1'b1;
                            state       <= WAIT_STOP;
                        end else if (scl_fall) begin
                            shreg        <= txbyte_i;
                            txbyte_deq_o <= 1'b1;
                            I2C_SDADR0_o <= ~txbyte_i[7];
                            state        <= RD_DATA;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master plus a transaction-level model of the
// expected ACKs, read data and device-side strobes.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam logic [6:0] MY_ADDR7 = 7'h21;
    localparam logic [1:0] K_RX     = 2'd1;
    localparam logic [1:0] K_DEQ    = 2'd2;
    localparam logic [1:0] K_NACK   = 2'd3;

    logic       clk6x = 1'b0;
    logic       resetn = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl = 1'b1;
    logic [7:0] txbyte = 8'h00;
    logic       sda_bus;
    logic       sda_dr, devsel, rw_bit, rxbyte_v, txbyte_deq, tx_nacked;
    logic [7:0] rxbyte;

    int         errors = 0;
    int         checks = 0;
    int         quarter_ns = 2500;
    bit         drive_allowed = 1'b0;
    bit         exp_devsel = 1'b0;
    bit         exp_rw = 1'b0;
    bit         wr_mode = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] cmp_entry;
    logic [1:0] cmp_kind;
    int         n_strobes;

    // Wired-AND of the master's line and the slave's pull-low request.
    assign sda_bus = sda_m & ~sda_dr;

    i2c_slave #(.SLAVE_ADDRESS(8'h42)) dut (
        .clk6x        (clk6x),
        .resetn       (resetn),
        .I2C_SDA      (sda_bus),
        .I2C_SDADR0_o (sda_dr),
        .I2C_SCL_i    (scl),
        .devsel_o     (devsel),
        .rw_bit_o     (rw_bit),
        .rxbyte_o     (rxbyte),
        .rxbyte_v_o   (rxbyte_v),
        .txbyte_i     (txbyte),
        .txbyte_deq_o (txbyte_deq),
        .tx_nacked_o  (tx_nacked)
    );

    always #10 clk6x = ~clk6x;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Strobes must arrive in the order the model predicted; SDA may only be pulled when the model allows it.
    always @(negedge clk6x) begin
        if (resetn == 1'b0) begin
            n_strobes = int'(rxbyte_v) + int'(txbyte_deq) + int'(tx_nacked);
            if (n_strobes != 0) begin
                check_output("strobe_count", n_strobes, 1);
                cmp_kind = rxbyte_v ? K_RX : (txbyte_deq ? K_DEQ : K_NACK);
                if (exp_q.size() == 0) begin
                    check_output("unexpected_strobe", {30'd0, cmp_kind}, 0);
                end else begin
                    cmp_entry = exp_q.pop_front();
                    check_output("strobe_kind", {30'd0, cmp_kind}, {30'd0, cmp_entry[9:8]});
                    if (cmp_entry[9:8] == K_RX)
                        check_output("rxbyte", {24'd0, rxbyte}, {24'd0, cmp_entry[7:0]});
                end
            end
            if (!drive_allowed)
                check_output("sda_release", {31'd0, sda_dr}, 0);
        end
    end

    task automatic do_bit(input logic b, output logic sampled);
        #(quarter_ns);
        sda_m = b;
        #(quarter_ns);
        scl = 1'b1;
        #(quarter_ns);
        @(negedge clk6x);
        sampled = sda_bus;
        check_output("devsel", {31'd0, devsel}, {31'd0, exp_devsel});
        if (exp_devsel)
            check_output("rw_bit", {31'd0, rw_bit}, {31'd0, exp_rw});
        #(quarter_ns);
        scl = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--)
            do_bit(b[i], s);
    endtask

    task automatic start_cond(input bit repeated);
        if (repeated) begin
            #(quarter_ns);
            sda_m = 1'b1;
            #(quarter_ns);
            scl = 1'b1;
        end
        #(quarter_ns);
        sda_m = 1'b0;
        exp_devsel = 1'b0;
        wr_mode = 1'b0;
        #(quarter_ns);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        #(quarter_ns);
        sda_m = 1'b0;
        #(quarter_ns);
        scl = 1'b1;
        #(quarter_ns);
        sda_m = 1'b1;
        exp_devsel = 1'b0;
        wr_mode = 1'b0;
        #(quarter_ns);
        repeat (4) @(posedge clk6x);
    endtask

    task automatic send_address(input logic [7:0] b);
        logic s;
        bit   match;
        match = (b[7:1] == MY_ADDR7);
        send_bits(b);
        exp_devsel = match;
        exp_rw = b[0];
        wr_mode = match & ~b[0];
        if (match) drive_allowed = 1'b1;
        if (match && b[0]) exp_q.push_back({K_DEQ, 8'h00});
        do_bit(1'b1, s);
        check_output("addr_ack", {31'd0, s}, match ? 0 : 1);
        if (!(match && b[0])) begin
            repeat (8) @(posedge clk6x);
            drive_allowed = 1'b0;
        end
    endtask

    task automatic send_data(input logic [7:0] b);
        logic s;
        send_bits(b);
        if (wr_mode) begin
            exp_q.push_back({K_RX, b});
            drive_allowed = 1'b1;
        end
        do_bit(1'b1, s);
        check_output("data_ack", {31'd0, s}, wr_mode ? 0 : 1);
        repeat (8) @(posedge clk6x);
        drive_allowed = 1'b0;
    endtask

    task automatic read_data(output logic [7:0] r, input logic ack, input logic [7:0] next_tx);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            do_bit(1'b1, s);
            r[i] = s;
            if (i == 7) txbyte = next_tx;
        end
        repeat (8) @(posedge clk6x);
        drive_allowed = 1'b0;
        exp_q.push_back(ack ? {K_NACK, 8'h00} : {K_DEQ, 8'h00});
        do_bit(ack, s);
        if (!ack) drive_allowed = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r;
        repeat (5) @(posedge clk6x);
        @(negedge clk6x);
        check_output("reset_sda",    {31'd0, sda_dr}, 0);
        check_output("reset_devsel", {31'd0, devsel}, 0);
        check_output("reset_rw",     {31'd0, rw_bit}, 0);
        check_output("reset_rxbyte", {24'd0, rxbyte}, 0);
        check_output("reset_strobes", {29'd0, rxbyte_v, txbyte_deq, tx_nacked}, 0);
        resetn = 1'b0;
        repeat (5) @(posedge clk6x);

        $display("[TB] write 0x42 0x23 0x45, SCL 10us");
        quarter_ns = 2500;
        start_cond(0);
        send_address(8'h42);
        send_data(8'h23);
        send_data(8'h45);
        stop_cond();
        check_output("wr_rxbyte_last", {24'd0, rxbyte}, 32'h45);
        check_output("wr_devsel_after_stop", {31'd0, devsel}, 0);
        check_output("wr_queue_empty", exp_q.size(), 0);

        $display("[TB] read 0x43: 0x56 ACK, 0xAB NACK");
        quarter_ns = 625;
        txbyte = 8'h56;
        start_cond(0);
        send_address(8'h43);
        read_data(r, 1'b0, 8'hAB);
        check_output("rd_byte1", {24'd0, r}, 32'h56);
        read_data(r, 1'b1, 8'h00);
        check_output("rd_byte2", {24'd0, r}, 32'hAB);
        check_output("rd_devsel_wait_stop", {31'd0, devsel}, 1);
        stop_cond();
        check_output("rd_devsel_after_stop", {31'd0, devsel}, 0);
        check_output("rd_queue_empty", exp_q.size(), 0);

        $display("[TB] wrong address 0x50");
        start_cond(0);
        send_address(8'h50);
        send_data(8'hA5);
        stop_cond();
        check_output("wa_devsel", {31'd0, devsel}, 0);
        check_output("wa_rxbyte_kept", {24'd0, rxbyte}, 32'h45);
        check_output("wa_queue_empty", exp_q.size(), 0);

        $display("[TB] repeated START write 0x11 then read");
        start_cond(0);
        send_address(8'h42);
        send_data(8'h11);
        start_cond(1);
        check_output("rs_rxbyte", {24'd0, rxbyte}, 32'h11);
        txbyte = 8'h3C;
        send_address(8'h43);
        check_output("rs_rw_bit", {31'd0, rw_bit}, 1);
        read_data(r, 1'b1, 8'h00);
        check_output("rs_rd_byte", {24'd0, r}, 32'h3C);
        stop_cond();
        check_output("rs_queue_empty", exp_q.size(), 0);

        $display("[TB] reset during address ACK");
        start_cond(0);
        send_bits(8'h42);
        exp_devsel = 1'b1;
        exp_rw = 1'b0;
        drive_allowed = 1'b1;
        #(quarter_ns);
        @(negedge clk6x);
        check_output("rst_ack_driven", {31'd0, sda_dr}, 1);
        @(posedge clk6x);
        #3;
        resetn = 1'b1;
        #1;
        check_output("rst_async_sda", {31'd0, sda_dr}, 0);
        check_output("rst_devsel", {31'd0, devsel}, 0);
        check_output("rst_rxbyte", {24'd0, rxbyte}, 0);
        drive_allowed = 1'b0;
        exp_devsel = 1'b0;
        wr_mode = 1'b0;
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (10) @(posedge clk6x);
        resetn = 1'b0;
        repeat (10) @(posedge clk6x);
        start_cond(0);
        send_address(8'h42);
        send_data(8'h7E);
        stop_cond();
        check_output("post_rst_rxbyte", {24'd0, rxbyte}, 32'h7E);
        check_output("post_rst_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C bus slave (7-bit addressing, standard/fast mode) that bridges an I2C master to a simple byte-stream device interface.
- Oversamples SCL/SDA with the system clock (clk6x, nominally 48 MHz), detects START/STOP, matches its address, ACKs, and delivers or fetches data bytes.
- Drives SDA only as an open-drain pull-low request; the external pad/wired-AND lives outside the block.

Parameters:
- SLAVE_ADDRESS, 8'h42: 8-bit address byte with R/W=0. Match on bits [7:1]; bit 0 ignored (0x42 = write, 0x43 = read).

Ports:
- clk6x  input  1  system clock, all logic on rising edge
- resetn  input  1  asynchronous, active-high reset (1 = reset asserted)
- I2C_SDA  input  1  resolved SDA bus level
- I2C_SDADR0_o  output  1  1 = pull SDA low; 0 = release
- I2C_SCL_i  input  1  SCL bus level
- devsel_o  output  1  transaction addressed to this slave is in progress
- rw_bit_o  output  1  R/nW bit of the address byte; valid while devsel_o=1
- rxbyte_o  output  8  last received data byte (write transfers)
- rxbyte_v_o  output  1  1-cycle strobe: rxbyte_o is new
- txbyte_i  input  8  next byte to send; must be valid whenever devsel_o=1 and rw_bit_o=1
- txbyte_deq_o  output  1  1-cycle strobe: txbyte_i was captured
- tx_nacked_o  output  1  1-cycle strobe: master NACKed a transmitted byte

Behaviour:
- Reset:
  - All outputs 0; rxbyte_o = 0x00.
  - FSM goes to IDLE; synchronizer registers are set to 1 (bus idle).
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer plus one history register.
  - Edges are detected on the synchronized signals.
  - Latency from pin to detected edge is at most 3 clk6x cycles.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are honored in any state.
  - START (including a repeated START) clears the bit counter, releases SDA, drops devsel_o, and enters ADDR.
  - STOP releases SDA, drops devsel_o, and enters IDLE.
- Bit timing:
  - Data is sampled on SCL rising edges.
  - The slave changes SDADR0 only on SCL falling edges.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: shift in 8 bits, MSB first. On the SCL fall after the 8th bit:
  - If bits [7:1] match: set devsel_o=1, set rw_bit_o to bit 0, assert SDADR0, go to ADDR_ACK.
  - Otherwise: go to WAIT_STOP and never drive SDA.
- ADDR_ACK: on the SCL fall ending the ACK slot:
  - If rw=0: release SDA, go to WR_DATA.
  - If rw=1: load txbyte_i into the shift register, pulse txbyte_deq_o, drive bit 7 (SDADR0 = ~bit), go to RD_DATA.
- WR_DATA: shift 8 bits. On the SCL fall after the 8th bit:
  - rxbyte_o <= byte, pulse rxbyte_v_o for 1 cycle.
  - Assert SDADR0 (ACK), go to WR_ACK.
- WR_ACK: on the SCL fall, release SDA, go to WR_DATA.
- RD_DATA: on each SCL fall, present the next bit. After the 8th bit's SCL fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the SCL rise.
  - If 0 (ACK): on the SCL fall, load txbyte_i, pulse txbyte_deq_o, drive bit 7, go to RD_DATA.
  - If 1 (NACK): pulse tx_nacked_o, release SDA, go to WAIT_STOP; devsel_o stays 1 until STOP or START.
- WAIT_STOP: ignore everything except START and STOP.
- Boundaries:
  - SDADR0 is never asserted in IDLE or WAIT_STOP.
  - A STOP/START arriving mid-byte aborts the byte with no rxbyte_v_o strobe.
  - Assertion of resetn at any time immediately releases SDA.
  - Only one strobe (rxbyte_v_o, txbyte_deq_o, tx_nacked_o) fires per event.

Test Plan:
- Write: START, 0x42, 0x23, 0x45, STOP, SCL period 10 us.
  - SDADR0=1 during all 3 ACK slots; devsel_o=1 and rw_bit_o=0 after the address.
  - rxbyte_v_o pulses with rxbyte_o=0x23, then 0x45; devsel_o=0 after STOP.
- Read: START, 0x43, txbyte_i=0x56, master ACKs byte 1, txbyte_i=0xAB, master NACKs byte 2, STOP.
  - Bus reads back 0x56 then 0xAB; two txbyte_deq_o pulses; one tx_nacked_o pulse after byte 2.
- Wrong address: START, 0x50, data, STOP.
  - No ACK; SDADR0 stays 0; devsel_o stays 0; no strobes.
- Repeated START: write 0x42 + 0x11, then START, 0x43.
  - rxbyte 0x11 received; rw_bit_o switches to 1; read proceeds.
- Reset asserted mid-ACK: SDADR0 drops asynchronously; all outputs 0; the next START/0x42 transaction works normally.
